// File: rtl/pipeline_idc_queue.sv
// pipeline_idc_queue: decode-control stage between IF and EX.
// Each accepted instruction is decoded once (immediate + control fields).
// The decoded micro-op is buffered in a DEPTH-entry FIFO. The FIFO head is
// presented to EX over a valid/ready handshake. An empty queue presents an
// all-zero bubble (NOP).
// Optional build macro IDC_PERF_CNT_EN adds two performance counters:
//   perf_stall_cycles - counts cycles where IF offers an instruction but is
//                       refused for lack of space.
//   perf_flush_drops  - accumulates the uops discarded by flushes.
module pipeline_idc_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction_in,
    input  logic [XLEN-1:0]  pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic             rf_wr_en,
    output logic             do_jump,
    output logic             is_branch,
    output logic             is_debug,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       BrType,
    output logic [1:0]       rf_wr_sel,
    output logic [2:0]       dm_rd_ctrl,
    output logic [2:0]       dm_wr_ctrl,
    output logic [CNT_W-1:0] occupancy
`ifdef IDC_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flush_drops
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // RV opcodes recognised by the decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // ALU adder op; other ops are {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD = 4'd0;

    // One buffered micro-op: everything EX/MEM need, decode never re-run
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            rf_wr_en;
        logic            do_jump;
        logic            is_branch;
        logic            is_debug;
        logic            alu_a_sel;
        logic            alu_b_sel;
        logic [3:0]      alu_ctrl;
        logic [2:0]      br_type;
        logic [1:0]      rf_wr_sel;
        logic [2:0]      dm_rd_ctrl;
        logic [2:0]      dm_wr_ctrl;
    } uop_t;

    // Immediate generator: format chosen by opcode, sign-extended to XLEN
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst);
        logic signed [31:0]     raw;
        logic signed [XLEN-1:0] ext;
        case (inst[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                raw = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                raw = {inst[31:12], 12'b0};
            OPC_JAL:
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                raw = '0;
        endcase
        ext = XLEN'(raw);
        return ext;
    endfunction

    // Load width/sign code: 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=LWU 7=LD, 0=none
    function automatic logic [2:0] ld_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'd1;
            3'b100:  return 3'd2;
            3'b001:  return 3'd3;
            3'b101:  return 3'd4;
            3'b010:  return 3'd5;
            3'b110:  return 3'd6;
            3'b011:  return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Store width code: 1=SB 2=SH 3=SW 4=SD, 0=none
    function automatic logic [2:0] st_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'd1;
            3'b001:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    uop_t             dec_uop;
    uop_t             head_uop;
    uop_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             enq;
    logic             deq;
    logic [2:0]       f3;

    assign f3 = instruction_in[14:12];

    // Combinational decode of the offered instruction
    always_comb begin
        dec_uop     = '0;
        dec_uop.pc  = pc_in;
        dec_uop.rd  = instruction_in[11:7];
        dec_uop.rs1 = instruction_in[19:15];
        dec_uop.rs2 = instruction_in[24:20];
        dec_uop.imm = imm_gen(instruction_in);
        case (instruction_in[6:0])
            OPC_LUI: begin
                dec_uop.rf_wr_en  = 1'b1;
                dec_uop.rf_wr_sel = WB_IMM;
            end
            OPC_AUIPC: begin
                dec_uop.rf_wr_en  = 1'b1;
                dec_uop.alu_a_sel = 1'b1;
                dec_uop.alu_b_sel = 1'b1;
                dec_uop.alu_ctrl  = ALU_ADD;
            end
            OPC_JAL: begin
                dec_uop.rf_wr_en  = 1'b1;
                dec_uop.do_jump   = 1'b1;
                dec_uop.alu_a_sel = 1'b1;
                dec_uop.alu_b_sel = 1'b1;
                dec_uop.rf_wr_sel = WB_PC4;
            end
            OPC_JALR: begin
                dec_uop.rf_wr_en  = 1'b1;
                dec_uop.do_jump   = 1'b1;
                dec_uop.alu_b_sel = 1'b1;
                dec_uop.rf_wr_sel = WB_PC4;
            end
            OPC_BRANCH: begin
                // ALU forms the target pc+imm; the compare uses rs1/rs2
                dec_uop.is_branch = 1'b1;
                dec_uop.alu_a_sel = 1'b1;
                dec_uop.alu_b_sel = 1'b1;
                dec_uop.br_type   = f3;
            end
            OPC_LOAD: begin
                dec_uop.rf_wr_en   = 1'b1;
                dec_uop.alu_b_sel  = 1'b1;
                dec_uop.rf_wr_sel  = WB_MEM;
                dec_uop.dm_rd_ctrl = ld_ctrl(f3);
            end
            OPC_STORE: begin
                dec_uop.alu_b_sel  = 1'b1;
                dec_uop.dm_wr_ctrl = st_ctrl(f3);
            end
            OPC_OPIMM: begin
                // bit 30 only selects SRAI; elsewhere it is immediate data
                dec_uop.rf_wr_en  = 1'b1;
                dec_uop.alu_b_sel = 1'b1;
                dec_uop.alu_ctrl  = {instruction_in[30] && (f3 == 3'b101), f3};
            end
            OPC_OP: begin
                dec_uop.rf_wr_en = 1'b1;
                dec_uop.alu_ctrl = {instruction_in[30] && ((f3 == 3'b000) || (f3 == 3'b101)), f3};
            end
            OPC_SYSTEM: begin
                dec_uop.is_debug = (instruction_in == 32'h0010_0073);
            end
            default: begin
                dec_uop.imm = '0;
            end
        endcase
    end

    // Handshake qualifiers; flush blocks both sides and wins over them
    assign in_ready  = (occ_q < DEPTH_C) && !flush;
    assign out_valid = (occ_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready && !flush;
    assign occupancy = occ_q;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state: async reset discards every buffered uop at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage: written only on enqueue; stale entries are never visible
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= dec_uop;
    end

    // Head entry, replaced by an all-zero bubble whenever the queue is empty
    always_comb begin
        head_uop = '0;
        if (out_valid) head_uop = mem_q[rd_ptr_q];
    end

    assign pc_out     = head_uop.pc;
    assign rd         = head_uop.rd;
    assign rs1        = head_uop.rs1;
    assign rs2        = head_uop.rs2;
    assign imm        = head_uop.imm;
    assign rf_wr_en   = head_uop.rf_wr_en;
    assign do_jump    = head_uop.do_jump;
    assign is_branch  = head_uop.is_branch;
    assign is_debug   = head_uop.is_debug;
    assign alu_a_sel  = head_uop.alu_a_sel;
    assign alu_b_sel  = head_uop.alu_b_sel;
    assign alu_ctrl   = head_uop.alu_ctrl;
    assign BrType     = head_uop.br_type;
    assign rf_wr_sel  = head_uop.rf_wr_sel;
    assign dm_rd_ctrl = head_uop.dm_rd_ctrl;
    assign dm_wr_ctrl = head_uop.dm_wr_ctrl;

`ifdef IDC_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] drops_q;

    // Refused-offer cycles and flushed-uop totals, both wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            if (in_valid && !in_ready && !flush) stall_q <= stall_q + 32'd1;
            if (flush) drops_q <= drops_q + 32'(occ_q);
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flush_drops  = drops_q;
`endif

endmodule
